// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: decoder/datapath/memory-side signals of the main control FSM.
// master = the control FSM, slave = the datapath and memory side that drives the
// opcode, flags and handshake inputs.
interface mc_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       blt;
    logic       bge;
    logic       bltu;
    logic       bgeu;
    logic       mem_ready;
    logic       stall;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       mem_req;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       mem_err;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, zero, blt, bge, bltu, bgeu, mem_ready, stall,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_req,
               ResultSrc, ALUSrcA, ALUSrcB, alu_op, instr_done, mem_err, state_o
    );

    modport slave (
        output opcode, funct3, zero, blt, bge, bltu, bgeu, mem_ready, stall,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_req,
               ResultSrc, ALUSrcA, ALUSrcB, alu_op, instr_done, mem_err, state_o
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control FSM of the multicycle RV32I core with a
// request/ready memory handshake, wait-state timeout, retire pulse and fetch stall.
// Optional macro MC_CTRL_TRAP_EN: illegal opcodes and memory timeouts enter a
// sticky TRAP state instead of returning to FETCH.
module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11
`ifdef MC_CTRL_TRAP_EN
        , TRAP   = 4'd12
`endif
    } state_t;

`ifdef MC_CTRL_TRAP_EN
    localparam state_t ABORT_ST = TRAP;
`else
    localparam state_t ABORT_ST = FETCH;
`endif

    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] cnt, cnt_n;
    logic                 timeout;
    logic                 pc_write, adr_src, mem_write, ir_write, reg_write;
    logic                 mem_req, instr_done, mem_err;
    logic [1:0]           result_src, alu_src_a, alu_src_b, alu_op;

    // Wait counter reached the limit and memory still has not answered.
    assign timeout = (cnt == TIMEOUT_W'(MEM_TIMEOUT)) && !bus.mem_ready;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, wait-counter update and datapath controls; the counter clears
    // on every cycle that is not a not-ready memory wait.
    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_req    = 1'b0;
        instr_done = 1'b0;
        mem_err    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                if (!bus.stall) begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        result_src = 2'b10;
                        state_n    = DECODE;
                    end else if (timeout) begin
                        mem_err = 1'b1;
                        state_n = ABORT_ST;
                    end else begin
                        cnt_n = cnt + TIMEOUT_W'(1);
                    end
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) begin
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    reg_write  = 1'b1;
                end else begin
                    alu_src_b = 2'b01;
                end
                case (bus.opcode)
                    OP_R:              state_n = EXEC_R;
                    OP_I, OP_LUI:      state_n = EXEC_I;
                    OP_AUIPC:          state_n = ALU_WB;
                    OP_LOAD, OP_STORE: state_n = MEM_ADDR;
                    OP_BRANCH:         state_n = BRANCH;
                    OP_JAL:            state_n = JAL;
                    OP_JALR:           state_n = JALR;
                    default: begin
`ifdef MC_CTRL_TRAP_EN
                        state_n = TRAP;
`else
                        state_n    = FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_n   = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_n   = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_n   = (bus.opcode == OP_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_n = MEM_WB;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_n = ABORT_ST;
                end else begin
                    cnt_n = cnt + TIMEOUT_W'(1);
                end
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) begin
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                    state_n    = FETCH;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_n = ABORT_ST;
                end else begin
                    mem_write = 1'b1;
                    cnt_n     = cnt + TIMEOUT_W'(1);
                end
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                instr_done = 1'b1;
                state_n    = FETCH;
                case (bus.funct3)
                    3'b000:  pc_write = bus.zero;
                    3'b001:  pc_write = !bus.zero;
                    3'b100:  pc_write = bus.blt;
                    3'b101:  pc_write = bus.bge;
                    3'b110:  pc_write = bus.bltu;
                    3'b111:  pc_write = bus.bgeu;
                    default: pc_write = 1'b0;
                endcase
            end
            JAL, JALR: begin
                alu_src_a  = (state == JALR) ? 2'b10 : 2'b01;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
`ifdef MC_CTRL_TRAP_EN
            TRAP: state_n = TRAP;
`endif
            default: state_n = FETCH;
        endcase
    end

    // Reset forces every output low without waiting for a clock edge.
    assign bus.PCWrite    = rst & pc_write;
    assign bus.AdrSrc     = rst & adr_src;
    assign bus.MemWrite   = rst & mem_write;
    assign bus.IRWrite    = rst & ir_write;
    assign bus.RegWrite   = rst & reg_write;
    assign bus.mem_req    = rst & mem_req;
    assign bus.instr_done = rst & instr_done;
    assign bus.mem_err    = rst & mem_err;
    assign bus.ResultSrc  = rst ? result_src : 2'b00;
    assign bus.ALUSrcA    = rst ? alu_src_a : 2'b00;
    assign bus.ALUSrcB    = rst ? alu_src_b : 2'b00;
    assign bus.alu_op     = rst ? alu_op : 2'b00;
    assign bus.state_o    = rst ? 4'(state) : 4'd0;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed and random stimulus for mc_ctrl_fsm against an
// instruction-level reference model (per-opcode state path plus wait counting).
module tb_mc_ctrl_fsm;
    localparam int unsigned TO = 4;
`ifdef MC_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam int B_ERR = 0, B_DONE = 1, B_REQ = 10, B_RW = 11, B_MW = 13, B_ADR = 14, B_PCW = 15;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_errors = 0;
    int          plan[$];
    int          m_wait = 0;
    logic [15:0] g_outs;
    int          g_state;

    mc_ctrl_fsm_if bus ();
    mc_ctrl_fsm #(.TIMEOUT_W(8), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

    // Full list of states an instruction visits after its fetch completes.
    task automatic load_plan(input logic [6:0] op);
        plan.delete();
        plan.push_back(1);
        case (op)
            OP_R:         begin plan.push_back(2); plan.push_back(4); end
            OP_I, OP_LUI: begin plan.push_back(3); plan.push_back(4); end
            OP_AUIPC:     plan.push_back(4);
            OP_LOAD:      begin plan.push_back(5); plan.push_back(6); plan.push_back(7); end
            OP_STORE:     begin plan.push_back(5); plan.push_back(8); end
            OP_BRANCH:    plan.push_back(9);
            OP_JAL:       plan.push_back(10);
            OP_JALR:      plan.push_back(11);
            default:      if (TRAP_EN) plan.push_back(12);
        endcase
    endtask

    function automatic int model_cur();
        return (plan.size() == 0) ? 0 : plan[0];
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [4:0] fl);
        case (f3)
            3'd0:    return fl[4];
            3'd1:    return !fl[4];
            3'd4:    return fl[3];
            3'd5:    return fl[2];
            3'd6:    return fl[1];
            3'd7:    return fl[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] pack(input logic pcw, adr, mw, irw, rw, req,
                                         input logic [1:0] rs, sa, sb, aop, input logic done, err);
        return {pcw, adr, mw, irw, rw, req, rs, sa, sb, aop, done, err};
    endfunction

    function automatic logic [15:0] pack_dut();
        return pack(bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.mem_req,
                    bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.alu_op, bus.instr_done, bus.mem_err);
    endfunction

    // Expected controls for one cycle, given the model's current state and inputs.
    function automatic logic [15:0] exp_out(input int cur, input logic stl, rdy, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [4:0] fl);
        logic pcw, adr, mw, irw, rw, req, done, err, tmo;
        logic [1:0] rs, sa, sb, aop;
        {pcw, adr, mw, irw, rw, req, done, err} = 8'h00;
        {rs, sa, sb, aop} = 8'h00;
        tmo = !rdy && (m_wait == TO);
        case (cur)
            0: if (!stl) begin
                req = 1'b1;
                if (rdy) begin irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10; end
                err = tmo;
            end
            1: begin
                sa = 2'b01;
                if (op == OP_JAL || op == OP_JALR) begin sb = 2'b10; rs = 2'b10; rw = 1'b1; end
                else sb = 2'b01;
                done = !is_legal(op) && !TRAP_EN;
            end
            2: begin sa = 2'b10; aop = 2'b10; end
            3: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            4: begin rw = 1'b1; done = 1'b1; end
            5: begin sa = 2'b10; sb = 2'b01; end
            6: begin req = 1'b1; adr = 1'b1; err = tmo; end
            7: begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
            8: begin req = 1'b1; adr = 1'b1; err = tmo; mw = !tmo; done = rdy; end
            9: begin sa = 2'b10; aop = 2'b01; done = 1'b1; pcw = branch_taken(f3, fl); end
            10, 11: begin
                sa = (cur == 11) ? 2'b10 : 2'b01; sb = 2'b01; rs = 2'b10; pcw = 1'b1; done = 1'b1;
            end
            default: ;
        endcase
        return pack(pcw, adr, mw, irw, rw, req, rs, sa, sb, aop, done, err);
    endfunction

    task automatic abort_access();
        plan.delete();
        m_wait = 0;
        if (TRAP_EN) plan.push_back(12);
    endtask

    // Advance the model by one clock.
    task automatic model_step(input logic r, stl, rdy, input logic [6:0] op);
        int cur;
        cur = model_cur();
        if (!r) begin
            plan.delete();
            m_wait = 0;
        end else if (cur == 0) begin
            if (stl) m_wait = 0;
            else if (rdy) begin load_plan(op); m_wait = 0; end
            else if (m_wait == TO) abort_access();
            else m_wait++;
        end else if (cur == 6 || cur == 8) begin
            if (rdy) begin void'(plan.pop_front()); m_wait = 0; end
            else if (m_wait == TO) abort_access();
            else m_wait++;
        end else if (cur != 12) begin
            void'(plan.pop_front());
        end
    endtask

    // Drive one cycle at the falling edge, check outputs, clock, advance the model.
    task automatic run_cycle(input logic r, stl, rdy, input logic [6:0] op,
                             input logic [2:0] f3, input logic [4:0] fl);
        int cur;
        logic [15:0] exp;
        rst = r;
        bus.stall = stl;
        bus.mem_ready = rdy;
        bus.opcode = op;
        bus.funct3 = f3;
        {bus.zero, bus.blt, bus.bge, bus.bltu, bus.bgeu} = fl;
        #1;
        cur = model_cur();
        exp = r ? exp_out(cur, stl, rdy, op, f3, fl) : 16'h0;
        g_outs = pack_dut();
        g_state = int'(bus.state_o);
        check($sformatf("outs st%0d", cur), 32'(g_outs), 32'(exp));
        check("state_o", 32'(bus.state_o), r ? 32'(cur) : 32'd0);
        @(posedge clk);
        model_step(r, stl, rdy, op);
        @(negedge clk);
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 9))
            0: return OP_R;
            1: return OP_I;
            2: return OP_LUI;
            3: return OP_AUIPC;
            4: return OP_LOAD;
            5: return OP_STORE;
            6: return OP_BRANCH;
            7: return OP_JAL;
            8: return OP_JALR;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] seq;
        logic [3:0]  done_bits;
        int          n_a, n_b, n_c;
        logic [6:0]  cur_op;
        rst = 1'b0;
        bus.stall = 1'b0; bus.mem_ready = 1'b0; bus.opcode = '0; bus.funct3 = '0;
        {bus.zero, bus.blt, bus.bge, bus.bltu, bus.bgeu} = 5'b0;
        @(negedge clk);

        // Reset holds everything low even with a ready memory.
        run_cycle(0, 0, 1, OP_R, 3'd0, 5'd0);
        run_cycle(0, 0, 1, OP_R, 3'd0, 5'd0);
        check("rst_req", 32'(g_outs[B_REQ]), 32'd0);

        // ADD with zero-wait memory: states 0,1,2,4 and retire on cycle 4.
        seq = '0; done_bits = '0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 0, 1, OP_R, 3'd0, 5'd0);
            seq = {seq[11:0], 4'(g_state)};
            done_bits = {done_bits[2:0], g_outs[B_DONE]};
        end
        check("add_seq", 32'(seq), 32'h0124);
        check("add_done", 32'(done_bits), 32'b0001);
        check("add_wb", 32'({g_outs[B_RW], g_outs[9:8]}), 32'b100);
        check("add_fetch", 32'(bus.state_o), 32'd0);

        // LW with 3 wait cycles in MEM_RD: 8 cycles total.
        n_a = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1, 0, (i == 0 || i >= 6), OP_LOAD, 3'd2, 5'd0);
            if (g_outs[B_REQ] && g_outs[B_ADR]) n_a++;
        end
        check("lw_req_cycles", 32'(n_a), 32'd4);
        check("lw_wb", 32'({g_state[3:0], g_outs[B_RW], g_outs[9:8]}), 32'({4'd7, 3'b101}));
        check("lw_fetch", 32'(bus.state_o), 32'd0);

        // Branch decisions: BNE taken, BEQ not taken, funct3=010 never.
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 1, OP_BRANCH, 3'b001, 5'b00000);
        check("bne_pcw", 32'(g_outs[B_PCW]), 32'd1);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 1, OP_BRANCH, 3'b000, 5'b01111);
        check("beq_pcw", 32'(g_outs[B_PCW]), 32'd0);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 1, OP_BRANCH, 3'b010, 5'b11111);
        check("f3_010_pcw", 32'(g_outs[B_PCW]), 32'd0);

        // SW timeout: 4 MemWrite cycles, error on the 5th, no retire.
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1, 0, (i == 0), OP_STORE, 3'd2, 5'd0);
            n_a += int'(g_outs[B_MW]);
            n_b += int'(g_outs[B_DONE]);
            if (i < 7) n_c += int'(g_outs[B_ERR]);
        end
        check("sw_mw_cycles", 32'(n_a), 32'd4);
        check("sw_no_done", 32'(n_b), 32'd0);
        check("sw_err_early", 32'(n_c), 32'd0);
        check("sw_err_5th", 32'(g_outs[B_ERR]), 32'd1);
        check("sw_abort_st", 32'(bus.state_o), TRAP_EN ? 32'd12 : 32'd0);
        run_cycle(0, 0, 0, OP_R, 3'd0, 5'd0);

        // Illegal opcode: NOP retire, or sticky TRAP through 20 cycles.
        run_cycle(1, 0, 1, 7'b0000000, 3'd0, 5'd0);
        run_cycle(1, 0, 1, 7'b0000000, 3'd0, 5'd0);
        check("ill_done", 32'(g_outs[B_DONE]), TRAP_EN ? 32'd0 : 32'd1);
        check("ill_no_wr", 32'({g_outs[B_RW], g_outs[B_PCW]}), 32'd0);
        for (int i = 0; i < 20; i++) run_cycle(1, 1, 1, OP_R, 3'd0, 5'd0);
        check("ill_hold", 32'(g_state), TRAP_EN ? 32'd12 : 32'd0);
        run_cycle(0, 0, 0, OP_R, 3'd0, 5'd0);

        // Stall clears a partly counted fetch wait: full timeout budget afterwards.
        run_cycle(1, 0, 0, OP_R, 3'd0, 5'd0);
        run_cycle(1, 0, 0, OP_R, 3'd0, 5'd0);
        n_a = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 1, 0, OP_R, 3'd0, 5'd0);
            n_a += int'(g_outs[B_REQ]);
        end
        check("stall_no_req", 32'(n_a), 32'd0);
        n_b = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 0, 0, OP_R, 3'd0, 5'd0);
            n_b += int'(g_outs[B_ERR]);
        end
        check("stall_cnt_clr", 32'(n_b), 32'd0);
        run_cycle(1, 0, 0, OP_R, 3'd0, 5'd0);
        check("fetch_tmo", 32'(g_outs[B_ERR]), 32'd1);
        run_cycle(0, 0, 0, OP_R, 3'd0, 5'd0);

        // Reset mid-fetch drops mem_req immediately.
        rst = 1'b1; bus.stall = 1'b0; bus.mem_ready = 1'b0;
        #1;
        check("fetch_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_async_req", 32'(bus.mem_req), 32'd0);
        check("rst_async_st", 32'(bus.state_o), 32'd0);
        plan.delete(); m_wait = 0;
        @(negedge clk);

        // Reset mid-store drops MemWrite immediately.
        for (int i = 0; i < 4; i++) run_cycle(1, 0, (i == 0), OP_STORE, 3'd2, 5'd0);
        bus.mem_ready = 1'b0;
        #1;
        check("mw_before_rst", 32'(bus.MemWrite), 32'd1);
        rst = 1'b0;
        #1;
        check("mw_async_rst", 32'({bus.MemWrite, bus.mem_req}), 32'd0);
        plan.delete(); m_wait = 0;
        @(negedge clk);

        // Random instruction streams, memory latency, stalls and resets.
        cur_op = OP_R;
        for (int i = 0; i < 3000; i++) begin
            if (model_cur() == 0) cur_op = pick_op();
            run_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 1)), cur_op, 3'($urandom_range(0, 7)),
                      5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
